// File: rtl/srl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : srl_fifo
//  Purpose  : First-word-fall-through FIFO on an addressable shift chain.
//             Every write shifts the whole chain one entry deeper. The oldest
//             word is read combinationally from index (count - 1).
//  Revision : 1.0 - initial release
// ============================================================================
module srl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // Shift-chain storage. It is never reset, so words above the occupancy
   // count are don't-care.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] rd_data;

   // Handshake qualifiers. ready_o also drops while reset is held. A full FIFO
   // refuses writes even when a pop happens in the same cycle.
   assign ready_o = (count != FULL_COUNT) && RST_N;
   assign valid_o = (count != '0);
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;
   assign count_o = count;
   assign data_o  = rd_data;

   // Shift the chain on every accepted write. The new word lands at index 0.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[0] <= data_i;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   // Next occupancy. A push and a pop together leave the count unchanged,
   // because the shift moves the next-oldest word into slot count-1.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Occupancy register. It clears asynchronously so the outputs idle
   // immediately when reset is asserted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

   // DEPTH:1 read mux addressed by count-1. Output is zero when empty.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count == CW'(i + 1)) begin
            rd_data = mem[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_srl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srl_fifo
//  Purpose  : Self-checking bench for srl_fifo (DEPTH=16 and DEPTH=2 copies)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_srl_fifo;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   // DEPTH = 16 instance
   logic       v16, r16, rdy16, val16;
   logic [7:0] d16, q16_o;
   logic [4:0] cnt16;
   // DEPTH = 2 instance
   logic       v2, r2, rdy2, val2;
   logic [7:0] d2, q2_o;
   logic [1:0] cnt2;

   logic [7:0] sb16[$];
   logic [7:0] sb2[$];

   srl_fifo #(.WIDTH(8), .DEPTH(16)) dut16 (
      .CLK(clk), .RST_N(rst_n), .valid_i(v16), .ready_o(rdy16), .data_i(d16),
      .valid_o(val16), .ready_i(r16), .data_o(q16_o), .count_o(cnt16));

   srl_fifo #(.WIDTH(8), .DEPTH(2)) dut2 (
      .CLK(clk), .RST_N(rst_n), .valid_i(v2), .ready_o(rdy2), .data_i(d2),
      .valid_o(val2), .ready_i(r2), .data_o(q2_o), .count_o(cnt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // A reset assertion discards every stored word at once.
   always @(negedge rst_n) begin
      sb16.delete();
      sb2.delete();
   end

   // Reference queues advance on every edge. A pop is scored against the
   // oldest queued word.
   always @(posedge clk) begin
      if (rst_n) begin
         automatic bit p16  = v16 && (sb16.size() < 16);
         automatic bit po16 = (sb16.size() != 0) && r16;
         automatic bit p2   = v2 && (sb2.size() < 2);
         automatic bit po2  = (sb2.size() != 0) && r2;
         if (po16) begin
            chk("pop16_data", q16_o, sb16[0]);
            void'(sb16.pop_front());
         end
         if (p16) sb16.push_back(d16);
         if (po2) begin
            chk("pop2_data", q2_o, sb2[0]);
            void'(sb2.pop_front());
         end
         if (p2) sb2.push_back(d2);
      end
   end

   // Mid-cycle comparison of every output against the reference queues.
   always @(negedge clk) begin
      chk("cnt16", cnt16, sb16.size());
      chk("val16", val16, sb16.size() != 0);
      chk("rdy16", rdy16, (sb16.size() != 16) && rst_n);
      chk("dat16", q16_o, (sb16.size() != 0) ? sb16[0] : 8'h00);
      chk("cnt2",  cnt2,  sb2.size());
      chk("val2",  val2,  sb2.size() != 0);
      chk("rdy2",  rdy2,  (sb2.size() != 2) && rst_n);
      chk("dat2",  q2_o,  (sb2.size() != 0) ? sb2[0] : 8'h00);
   end

   // Drive one cycle of inputs on the DEPTH=16 instance, then step past the edge.
   task automatic cyc(input bit v, input logic [7:0] d, input bit r);
      v16 = v; d16 = d; r16 = r;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_seq [8];

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0;
      v16 = 0; r16 = 0; d16 = 0;
      v2 = 0;  r2 = 0;  d2 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt", cnt16, 0);
      chk("rst_val", val16, 0);
      chk("rst_rdy", rdy16, 0);
      chk("rst_dat", q16_o, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_rdy", rdy16, 1);
      chk("rel_val", val16, 0);
      @(posedge clk); #1;

      // Load five words, then assert reset mid-cycle.
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
      chk("five_cnt", cnt16, 5);
      v16 = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", cnt16, 0);
      chk("mid_rst_val", val16, 0);
      chk("mid_rst_rdy", rdy16, 0);
      chk("mid_rst_dat", q16_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("rel2_rdy", rdy16, 1);
      chk("rel2_val", val16, 0);
      chk("rel2_cnt", cnt16, 0);
      @(posedge clk); #1;

      // Fill to full, then offer a 17th word.
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
      chk("full_cnt", cnt16, 16);
      chk("full_rdy", rdy16, 0);
      cyc(1'b1, 8'hAA, 1'b0);
      chk("full_ign_cnt", cnt16, 16);
      chk("full_ign_dat", q16_o, 8'h00);

      // Drain in order, then attempt pops while empty.
      for (int i = 0; i < 16; i++) begin
         v16 = 0; r16 = 1;
         #1;
         chk("drain_dat", q16_o, i);
         @(posedge clk); #1;
      end
      chk("empty_val", val16, 0);
      chk("empty_dat", q16_o, 0);
      chk("empty_cnt", cnt16, 0);
      repeat (3) cyc(1'b0, 8'h00, 1'b1);
      chk("underflow_cnt", cnt16, 0);

      // Simultaneous push/pop at count 3.
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      exp_seq = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
      for (int i = 0; i < 8; i++) begin
         v16 = 1; d16 = 8'h20 + 8'(i); r16 = 1;
         #1;
         chk("pp_cnt", cnt16, 3);
         chk("pp_dat", q16_o, exp_seq[i]);
         @(posedge clk); #1;
      end
      chk("pp_cnt_end", cnt16, 3);
      chk("pp_tail", q16_o, 8'h25);
      repeat (3) cyc(1'b0, 8'h00, 1'b1);
      chk("pp_drained", cnt16, 0);

      // Count-1 corner.
      cyc(1'b1, 8'h55, 1'b0);
      chk("c1_dat_before", q16_o, 8'h55);
      cyc(1'b1, 8'h66, 1'b1);
      chk("c1_cnt", cnt16, 1);
      chk("c1_dat", q16_o, 8'h66);
      cyc(1'b0, 8'h00, 1'b1);
      chk("c1_drained", cnt16, 0);

      // Random stress on both depths. The push bias alternates so that both
      // full and empty are visited.
      for (int i = 0; i < 10000; i++) begin
         automatic int bias = ((i / 300) % 2 == 0) ? 3 : 1;
         v16 = ($urandom_range(0, 3) < bias);
         r16 = ($urandom_range(0, 3) >= bias);
         d16 = 8'($urandom);
         v2  = $urandom_range(0, 1);
         r2  = $urandom_range(0, 1);
         d2  = 8'($urandom);
         @(posedge clk); #1;
      end
      v16 = 0; r16 = 0; v2 = 0; r2 = 0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/srl_fifo.md
# srl_fifo

Synchronous first-word-fall-through FIFO built on the addressable shift-register storage style: writes shift every entry one position deeper, and reads select the oldest entry by address, which is the occupancy count minus one. This block is the read/occupancy controller around that shift chain. It is the standard small-buffer primitive for the synchronous FIFO designs in this codebase. The downstream side sees the oldest word combinationally, with no read latency.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; legal range 2..16

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  asynchronous, active-low reset
- valid_i  in  1  upstream offers data_i
- ready_o  out  1  FIFO can accept a word this cycle
- data_i  in  WIDTH  write data
- valid_o  out  1  data_o holds the oldest stored word
- ready_i  in  1  downstream consumes data_o this cycle
- data_o  out  WIDTH  oldest word
- count_o  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage is `mem[0..DEPTH-1]`, one WIDTH-bit shift chain.
  - Storage has no reset; its contents are don't-care until written.
- Push = valid_i && ready_o.
  - On the edge, `mem <= {mem[DEPTH-2:0], data_i}`: the new word lands at index 0 and every entry moves one index deeper.
  - Storage shifts only on a push.
- Pop = valid_o && ready_i. A pop updates the count only; storage is untouched.
- Read address = count − 1; data_o = mem[count−1] when count ≠ 0.
  - data_o is forced to all-zero when count = 0.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged (the shift moves the next-oldest word into index count−1)
  - neither: unchanged
- ready_o = (count ≠ DEPTH) && RST_N. There is no full-bypass: when full, a simultaneous pop does not enable a push.
- valid_o = (count ≠ 0).
- count_o = count register.
- Boundaries:
  - Full: valid_i is ignored and storage is unchanged.
  - Empty: ready_i is ignored and count stays 0. There is no underflow wrap.
  - Push-only into an empty FIFO makes count 1; the word appears on data_o after that edge.
  - Simultaneous push and pop at count 1: count stays 1, and data_o becomes the new word.
- Reset mid-operation:
  - Count clears to 0 asynchronously and immediately; stored words are discarded logically.
  - A handshake in flight at reset assertion is not completed.
- Invariant: count never exceeds DEPTH and never goes below 0.

## Timing
- Reset values while RST_N = 0: count_o = 0, valid_o = 0, ready_o = 0, data_o = 0.
- First push is accepted on the first posedge after RST_N deasserts with valid_i = 1. ready_o is 1 in that cycle.
- Write-to-read latency is 1 edge: a word pushed at edge k is on data_o, with valid_o = 1, after edge k if the FIFO was empty.
- Read latency is 0: data_o and valid_o depend combinationally only on the count register and storage, never on ready_i.
- ready_o and valid_o depend only on state and RST_N, not on valid_i or ready_i. There are no combinational handshake loops.
- Sustained throughput is one push and one pop per cycle when 0 < count < DEPTH.
- The data path is a DEPTH:1 mux on the count register, and count_o updates on the same edge as the handshake.

## Test plan
- Reset/idle:
  - Stimulus: assert RST_N = 0 mid-cycle with count = 5.
  - Required: count_o = 0, valid_o = 0, ready_o = 0, data_o = 0 immediately, before the next edge.
  - Required after release: ready_o = 1, valid_o = 0.
- Fill to full (DEPTH = 16, WIDTH = 8):
  - Stimulus: push 0x00..0x0F with ready_i = 0.
  - Required: count_o climbs to 16 and ready_o = 0 after the 16th edge.
  - Stimulus: a 17th push of 0xAA is offered.
  - Required: it is ignored; data_o = 0x00 and count stays 16.
- Drain order:
  - Stimulus: from full, hold ready_i = 1 and valid_i = 0.
  - Required: data_o reads 0x00, 0x01, …, 0x0F on consecutive cycles.
  - Required after the 16th pop: valid_o = 0, data_o = 0, count_o = 0.
  - Stimulus: further pops are attempted.
  - Required: count stays 0.
- Simultaneous push/pop:
  - Stimulus: at count 3 holding 0x10, 0x11, 0x12, push 0x20..0x27 and pop every cycle for 8 cycles.
  - Required: count_o stays 3 throughout.
  - Required output sequence: 0x10, 0x11, 0x12, 0x20, … in order.
- Count-1 corner:
  - Stimulus: with a single entry 0x55, push 0x66 and pop on the same edge.
  - Required: count_o = 1 and data_o = 0x66 next cycle.
- Random stress:
  - Stimulus: 10,000 cycles of random valid_i and ready_i with DEPTH = 2 and DEPTH = 16.
  - Required: a scoreboard queue matches data_o on every pop.
  - Required every cycle: count_o equals scoreboard size, and no push is accepted while full.
